// File: rtl/danger_scheduler.sv
// Obstacle generator for the dino game: three scrolling slots with LFSR-driven spawning.
// Optional build macro BIRD_SPAWN_EN also lets bird obstacles spawn (cactus-only otherwise).
module danger_scheduler #(
  parameter int          SPAWN_X = 720,
  parameter int          MIN_GAP = 200,
  parameter logic [15:0] SEED    = 16'hACE1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       clear,
  input  logic       run,
  input  logic       tick,
  input  logic [3:0] speed,
  output logic [9:0] new_danger_pos1,
  output logic [9:0] new_danger_pos2,
  output logic [9:0] new_danger_pos3,
  output logic [2:0] danger_type1,
  output logic [2:0] danger_type2,
  output logic [2:0] danger_type3,
  output logic       danger_en1,
  output logic       danger_en2,
  output logic       danger_en3
);

  localparam logic [15:0] SEED_EFF  = (SEED == 16'h0000) ? 16'h0001 : SEED;
  localparam logic [9:0]  SPAWN_POS = 10'(SPAWN_X);
  localparam logic [10:0] SPAWN_X11 = 11'(SPAWN_X);
  localparam logic [10:0] MIN_GAP11 = 11'(MIN_GAP);
  localparam logic [2:0]  NOTHING   = 3'd5;

  typedef enum logic [1:0] {IDLE, MOVE, SPAWN} state_t;

  state_t      state_reg, state_next;
  logic [9:0]  pos_reg  [3];
  logic [9:0]  pos_next [3];
  logic [2:0]  kind_reg [3];
  logic [2:0]  kind_next[3];
  logic [2:0]  en_reg, en_next;
  logic [15:0] lfsr_reg, lfsr_next;

  logic [10:0] gap;
  logic        fits;
  logic [2:0]  free_sel;

  function automatic logic [2:0] pick_type(input logic [2:0] v);
`ifdef BIRD_SPAWN_EN
    return (v < 3'd5) ? v : v - 3'd3;
`else
    return 3'(v % 3'd3) + 3'd2;
`endif
  endfunction

  // Spacing check sees the positions already scrolled by the MOVE cycle.
  always_comb begin
    gap  = MIN_GAP11 + {3'b000, lfsr_reg[7:4], 4'b0000};
    fits = 1'b1;
    for (int i = 0; i < 3; i++) begin
      if (en_reg[i] && (({1'b0, pos_reg[i]} + gap) > SPAWN_X11)) fits = 1'b0;
    end
    free_sel[0] = ~en_reg[0];
    free_sel[1] = ~en_reg[1] & en_reg[0];
    free_sel[2] = ~en_reg[2] & en_reg[1] & en_reg[0];
  end

  always_comb begin
    state_next = state_reg;
    en_next    = en_reg;
    lfsr_next  = lfsr_reg;
    for (int i = 0; i < 3; i++) begin
      pos_next[i]  = pos_reg[i];
      kind_next[i] = kind_reg[i];
    end
    case (state_reg)
      IDLE: begin
        if (tick && run) state_next = MOVE;
      end
      MOVE: begin
        for (int i = 0; i < 3; i++) begin
          if (en_reg[i]) begin
            if (pos_reg[i] <= {6'd0, speed}) begin
              en_next[i]   = 1'b0;
              pos_next[i]  = 10'd0;
              kind_next[i] = NOTHING;
            end else begin
              pos_next[i] = pos_reg[i] - {6'd0, speed};
            end
          end
        end
        state_next = SPAWN;
      end
      SPAWN: begin
        lfsr_next = {lfsr_reg[14:0],
                     lfsr_reg[15] ^ lfsr_reg[13] ^ lfsr_reg[12] ^ lfsr_reg[10]};
        if (fits && (free_sel != 3'b000)) begin
          for (int i = 0; i < 3; i++) begin
            if (free_sel[i]) begin
              en_next[i]   = 1'b1;
              pos_next[i]  = SPAWN_POS;
              kind_next[i] = pick_type(lfsr_reg[2:0]);
            end
          end
        end
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg <= IDLE;
      en_reg    <= 3'b000;
      lfsr_reg  <= SEED_EFF;
      for (int i = 0; i < 3; i++) begin
        pos_reg[i]  <= 10'd0;
        kind_reg[i] <= NOTHING;
      end
    end else if (clear) begin
      state_reg <= IDLE;
      en_reg    <= 3'b000;
      lfsr_reg  <= SEED_EFF;
      for (int i = 0; i < 3; i++) begin
        pos_reg[i]  <= 10'd0;
        kind_reg[i] <= NOTHING;
      end
    end else begin
      state_reg <= state_next;
      en_reg    <= en_next;
      lfsr_reg  <= lfsr_next;
      for (int i = 0; i < 3; i++) begin
        pos_reg[i]  <= pos_next[i];
        kind_reg[i] <= kind_next[i];
      end
    end
  end

  assign new_danger_pos1 = pos_reg[0];
  assign new_danger_pos2 = pos_reg[1];
  assign new_danger_pos3 = pos_reg[2];
  assign danger_type1    = kind_reg[0];
  assign danger_type2    = kind_reg[1];
  assign danger_type3    = kind_reg[2];
  assign danger_en1      = en_reg[0];
  assign danger_en2      = en_reg[1];
  assign danger_en3      = en_reg[2];

endmodule

// File: doc/danger_scheduler.md
Name: danger_scheduler

Overview:
- Obstacle (danger) generator for the dino game. It feeds the danger renderer that sits directly downstream of it.
- Owns three obstacle slots. Each frame tick it scrolls every active slot left and retires slots that leave the screen.
- It then spawns a new pseudo-random obstacle into a free slot when the spacing rule allows.
- Outputs are registered and drive new_danger_pos1..3, danger_type1..3 and danger_en1..3 of the renderer.

Parameters:
- SPAWN_X, 720: right-edge x position given to a newly spawned obstacle. Must be 1..1023.
- MIN_GAP, 200: minimum px between SPAWN_X and the right edge of any active obstacle before a spawn is allowed.
- SEED, 16'hACE1: LFSR value loaded at reset and on clear. A value of 0 is replaced by 16'h0001.

Ports:
- clk  input  1  system clock
- rst  input  1  reset, asynchronous, active-low (0 = reset)
- clear  input  1  synchronous game restart
- run  input  1  1 = game running; 0 = ticks ignored and state frozen
- tick  input  1  one-cycle pulse, once per video frame
- speed  input  4  px moved per tick, 0..15
- new_danger_pos1/2/3  output  10  right-edge x of each slot
- danger_type1/2/3  output  3  0 LOW_BIRD, 1 HIGH_BIRD, 2 SMALL_CACTUS, 3 MANY_CACTUS, 4 BIG_CACTUS, 5 NOTHING
- danger_en1/2/3  output  1  slot active

Behaviour:
- Reset (rst=0, asynchronous):
  - all pos = 0, all type = 5, all en = 0
  - LFSR = SEED, FSM = IDLE
- clear=1 (synchronous, highest priority, acts in any state):
  - same values as reset at the next edge
  - overrides a tick arriving in the same cycle
- FSM states: IDLE, MOVE, SPAWN.
  - IDLE: on an edge with tick=1 and run=1, go to MOVE. Otherwise stay.
  - MOVE (one cycle), for each slot with en=1:
    - if pos <= speed: en←0, pos←0, type←5 (retire)
    - else: pos←pos−speed
    - disabled slots are unchanged
    - next state SPAWN
  - SPAWN (one cycle), using the positions just written in MOVE:
    - gap = MIN_GAP + {lfsr[7:4],4'b0}, range MIN_GAP..MIN_GAP+240, computed in 11 bits
    - spawn is allowed when at least one slot has en=0 and every slot with en=1 has pos + gap <= SPAWN_X
    - if allowed, the lowest-index free slot gets en←1, pos←SPAWN_X, type←f(lfsr[2:0])
    - the LFSR advances exactly once in SPAWN, whether or not a spawn occurs
    - next state IDLE
- Ticks seen while in MOVE or SPAWN are ignored.
- If run drops to 0 in MOVE or SPAWN, the sequence still completes. Further ticks are then ignored until run=1.
- Latency: outputs reflect a tick two clock edges after the edge that sampled it. Outputs are otherwise stable.
- LFSR:
  - 16-bit Fibonacci, polynomial x^16+x^14+x^13+x^11+1
  - shift left; new lsb = l[15]^l[13]^l[12]^l[10]
  - values used for gap and type are those held before the shift
- All slots full: no spawn, LFSR still advances.
- No slots active: spawn is always allowed.
- speed=0: no movement and no retirement.
- type is only ever 5 when en=0.

Optional Feature:
- Macro: BIRD_SPAWN_EN.
- Defined: f(v) = v if v<5, else v−3. All five types can occur; v=5,6,7 map to 2,3,4.
- Undefined: f(v) = 2 + (v mod 3). Only cactus types 2..4 are spawned.
- Retirement and NOTHING encoding are identical in both builds.

Test Plan:
1. rst=0 mid-run with slots active -> immediately all en=0, pos=0, type=5; after release, first spawn uses SEED again.
2. Spawn timing, after reset with clear=0, run=1, speed=8, single tick -> two edges later slot1 en=1, pos=720, type=1 (BIRD_SPAWN_EN) or type=3 (undefined); slots 2/3 en=0.
3. Scroll spacing, continue with ticks (speed=8) -> slot1 pos 712, 704, …; no second spawn while 720−pos1 < gap; slot2 spawns at 720 on the first tick where pos1+gap <= 720.
4. Retirement, slot pos=6 with speed=8, tick -> that slot en=0, pos=0, type=5; remaining slots decrease by 8; the freed slot is reusable at the next SPAWN.
5. Frozen and clear, run=0 with 10 ticks -> outputs and LFSR unchanged; then clear=1 and tick=1 in the same cycle -> all slots cleared, no movement, LFSR=SEED.
6. Saturation, all three slots active with speed=0 and ticks -> positions constant, no spawn, no slot overwritten.
